proc_control: RTL and testbench

- Multi-cycle control unit for the 16-bit datapath. It is the driving end of the ULA interface.
- Fetches an instruction word from DIN into an internal IR.
- Sequences register-file outputs, the A and G latches and the 2-bit ULA operation select over time steps T0..T3.
- Signals Done when the destination register is written.
- Sits between instruction memory/testbench (DIN, Run) and the datapath register file / bus mux.

---
 rtl/proc_pkg.sv | 43 ++++
 rtl/proc_control_if.sv | 29 ++
 rtl/dec3to8.sv | 15 +
 rtl/proc_control.sv | 134 +++++++++++++
 tb/tb_proc_control.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ULA select
// codes and the T0..T3 time-step encoding.
package proc_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int NREGS      = 8;

    localparam logic [3:0] OP_MV  = 4'b0000;
    localparam logic [3:0] OP_MVI = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b0101;

    localparam logic [1:0] ULA_ADD = 2'b00;
    localparam logic [1:0] ULA_SUB = 2'b01;
    localparam logic [1:0] ULA_SLT = 2'b10;
    localparam logic [1:0] ULA_CMP = 2'b11;

    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] opcode);
        return (opcode == OP_ADD) || (opcode == OP_SUB) ||
               (opcode == OP_SLT) || (opcode == OP_CMP);
    endfunction

    function automatic logic [1:0] ula_op(input logic [3:0] opcode);
        logic [1:0] op;
        case (opcode)
            OP_SUB:  op = ULA_SUB;
            OP_SLT:  op = ULA_SLT;
            OP_CMP:  op = ULA_CMP;
            default: op = ULA_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/proc_control_if.sv
// Control-unit to datapath interface: instruction/start inputs and the
// bus, latch and ULA control strobes.
interface proc_control_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NREGS      = 8
);
    logic                  Run;
    logic [DATA_WIDTH-1:0] DIN;
    logic                  IRin;
    logic [NREGS-1:0]      Rout;
    logic [NREGS-1:0]      Rin;
    logic                  DINout;
    logic                  Ain;
    logic                  Gin;
    logic                  Gout;
    logic [1:0]            Operacao;
    logic                  Done;
    logic                  Busy;

    modport master (
        input  Run, DIN,
        output IRin, Rout, Rin, DINout, Ain, Gin, Gout, Operacao, Done, Busy
    );

    modport slave (
        output Run, DIN,
        input  IRin, Rout, Rin, DINout, Ain, Gin, Gout, Operacao, Done, Busy
    );
endinterface

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_control.sv
// Multi-cycle control unit: fetches an instruction into IR and sequences the
// register file, A/G latches and ULA select over time steps T0..T3.
//
// state | meaning
// T0    | idle; accept instruction from DIN when Run is high
// T1    | mv/mvi/illegal complete here; ALU ops load A with Rx
// T2    | ALU ops: Ry onto bus, ULA result into G
// T3    | ALU ops: G written back to Rx, Done
module proc_control
    import proc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NREGS      = 8
) (
    input  logic Clock,
    input  logic Resetn,
    proc_control_if.master bus
);

    state_t                state;
    logic [DATA_WIDTH-1:0] ir;

    logic [3:0] opcode;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       unused_ir_low;

    assign opcode        = ir[15:12];
    assign rx            = ir[11:9];
    assign ry            = ir[8:6];
    assign unused_ir_low = ^ir[5:0];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= T0;
            ir    <= '0;
        end else begin
            case (state)
                T0: begin
                    if (bus.Run) begin
                        ir    <= bus.DIN;
                        state <= T1;
                    end
                end
                T1:      state <= is_alu_op(opcode) ? T2 : T0;
                T2:      state <= T3;
                default: state <= T0;
            endcase
        end
    end

    logic       irin_c;
    logic       dinout_c;
    logic       ain_c;
    logic       gin_c;
    logic       gout_c;
    logic       done_c;
    logic [1:0] op_c;
    logic       rout_x;
    logic       rout_y;
    logic       rin_en;

    always_comb begin
        irin_c   = 1'b0;
        dinout_c = 1'b0;
        ain_c    = 1'b0;
        gin_c    = 1'b0;
        gout_c   = 1'b0;
        done_c   = 1'b0;
        op_c     = ULA_ADD;
        rout_x   = 1'b0;
        rout_y   = 1'b0;
        rin_en   = 1'b0;
        case (state)
            // Gated by Resetn so nothing strobes while reset is held.
            T0: irin_c = bus.Run & Resetn;
            T1: begin
                if (opcode == OP_MV) begin
                    rout_y = 1'b1;
                    rin_en = 1'b1;
                    done_c = 1'b1;
                end else if (opcode == OP_MVI) begin
                    dinout_c = 1'b1;
                    rin_en   = 1'b1;
                    done_c   = 1'b1;
                end else if (is_alu_op(opcode)) begin
                    rout_x = 1'b1;
                    ain_c  = 1'b1;
                end else begin
                    done_c = 1'b1;
                end
            end
            T2: begin
                rout_y = 1'b1;
                gin_c  = 1'b1;
                op_c   = ula_op(opcode);
            end
            default: begin
                gout_c = 1'b1;
                rin_en = 1'b1;
                done_c = 1'b1;
            end
        endcase
    end

    // Rx is needed both as a source (T1 of ALU ops) and as the destination;
    // those uses never overlap, so one decoder serves both.
    logic [7:0] x_hot;
    logic [7:0] y_hot;

    dec3to8 u_dec_x (
        .en     (rout_x | rin_en),
        .sel    (rx),
        .onehot (x_hot)
    );

    dec3to8 u_dec_y (
        .en     (rout_y),
        .sel    (ry),
        .onehot (y_hot)
    );

    assign bus.IRin     = irin_c;
    assign bus.Rout     = (rout_x ? x_hot : 8'h00) | y_hot;
    assign bus.Rin      = rin_en ? x_hot : 8'h00;
    assign bus.DINout   = dinout_c;
    assign bus.Ain      = ain_c;
    assign bus.Gin      = gin_c;
    assign bus.Gout     = gout_c;
    assign bus.Operacao = op_c;
    assign bus.Done     = done_c;
    assign bus.Busy     = (state != T0);

endmodule

// File: tb/tb_proc_control.sv
// Directed bench for proc_control: reset, mvi, add, back-to-back ALU ops,
// illegal opcode and mid-instruction reset abort.
module tb_proc_control;

    logic Clock;
    logic Resetn;
    int   checks;
    int   errors;

    proc_control_if #(.DATA_WIDTH(16), .NREGS(8)) bus ();

    proc_control #(.DATA_WIDTH(16), .NREGS(8)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // {IRin, Rout, Rin, DINout, Ain, Gin, Gout, Operacao, Done, Busy}
    function automatic logic [24:0] mk(input logic irin, input logic [7:0] rout,
                                       input logic [7:0] rin, input logic dinout,
                                       input logic ain, input logic gin, input logic gout,
                                       input logic [1:0] op, input logic done,
                                       input logic busy);
        return {irin, rout, rin, dinout, ain, gin, gout, op, done, busy};
    endfunction

    function automatic logic [24:0] observed();
        return {bus.IRin, bus.Rout, bus.Rin, bus.DINout, bus.Ain, bus.Gin,
                bus.Gout, bus.Operacao, bus.Done, bus.Busy};
    endfunction

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        logic [24:0] obs;
        Resetn  = 1'b1;
        bus.Run = 1'b0;
        bus.DIN = 16'h0000;
        #1;
        Resetn  = 1'b0;
        bus.Run = 1'b1;
        bus.DIN = 16'h2280;
        for (int i = 0; i < 2; i++) begin
            #2;
            obs = observed();
            checks++;
            if (obs !== 25'h0) begin
                errors++;
                $display("FAIL reset_hold[%0d] got %h expected %h", i, obs, 25'h0);
            end
            next_cycle();
        end
        Resetn  = 1'b1;
        bus.Run = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            obs = observed();
            checks++;
            if (obs !== 25'h0) begin
                errors++;
                $display("FAIL reset_idle[%0d] got %h expected %h", i, obs, 25'h0);
            end
            next_cycle();
        end
    endtask

    task automatic test_mvi();
        logic [24:0] obs;
        logic [24:0] exp_v [3];
        logic        run_v [3];
        logic [15:0] din_v [3];
        run_v = '{1'b1, 1'b0, 1'b0};
        din_v = '{16'h1400, 16'h00A5, 16'h0000};
        exp_v[0] = mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);
        exp_v[1] = mk(0, 8'h00, 8'h04, 1, 0, 0, 0, 2'b00, 1, 1);
        exp_v[2] = 25'h0;
        for (int i = 0; i < 3; i++) begin
            bus.Run = run_v[i];
            bus.DIN = din_v[i];
            #2;
            obs = observed();
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL mvi_step[%0d] got %h expected %h", i, obs, exp_v[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_add();
        logic [24:0] obs;
        logic [24:0] exp_v [5];
        exp_v[0] = mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);
        exp_v[1] = mk(0, 8'h02, 8'h00, 0, 1, 0, 0, 2'b00, 0, 1);
        exp_v[2] = mk(0, 8'h04, 8'h00, 0, 0, 1, 0, 2'b00, 0, 1);
        exp_v[3] = mk(0, 8'h00, 8'h02, 0, 0, 0, 1, 2'b00, 1, 1);
        exp_v[4] = 25'h0;
        for (int i = 0; i < 5; i++) begin
            bus.Run = (i == 0);
            bus.DIN = 16'h2280;
            #2;
            obs = observed();
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL add_step[%0d] got %h expected %h", i, obs, exp_v[i]);
            end
            next_cycle();
        end
    endtask

    // slt R3,R4 ; cmp R5,R6 ; sub R3,R3 with Run held high throughout
    task automatic test_back_to_back();
        logic [24:0] obs;
        logic [24:0] exp_v [12];
        logic [15:0] instr [3];
        instr = '{16'h4700, 16'h5B80, 16'h36C0};
        exp_v[0]  = mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);
        exp_v[1]  = mk(0, 8'h08, 8'h00, 0, 1, 0, 0, 2'b00, 0, 1);
        exp_v[2]  = mk(0, 8'h10, 8'h00, 0, 0, 1, 0, 2'b10, 0, 1);
        exp_v[3]  = mk(0, 8'h00, 8'h08, 0, 0, 0, 1, 2'b00, 1, 1);
        exp_v[4]  = mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);
        exp_v[5]  = mk(0, 8'h20, 8'h00, 0, 1, 0, 0, 2'b00, 0, 1);
        exp_v[6]  = mk(0, 8'h40, 8'h00, 0, 0, 1, 0, 2'b11, 0, 1);
        exp_v[7]  = mk(0, 8'h00, 8'h20, 0, 0, 0, 1, 2'b00, 1, 1);
        exp_v[8]  = mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);
        exp_v[9]  = mk(0, 8'h08, 8'h00, 0, 1, 0, 0, 2'b00, 0, 1);
        exp_v[10] = mk(0, 8'h08, 8'h00, 0, 0, 1, 0, 2'b01, 0, 1);
        exp_v[11] = mk(0, 8'h00, 8'h08, 0, 0, 0, 1, 2'b00, 1, 1);
        bus.Run = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.DIN = instr[i / 4];
            #2;
            obs = observed();
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL b2b_step[%0d] got %h expected %h", i, obs, exp_v[i]);
            end
            next_cycle();
        end
        bus.Run = 1'b0;
        #2;
        obs = observed();
        checks++;
        if (obs !== 25'h0) begin
            errors++;
            $display("FAIL b2b_idle got %h expected %h", obs, 25'h0);
        end
        next_cycle();
    endtask

    task automatic test_illegal();
        logic [24:0] obs;
        logic [24:0] exp_v [3];
        exp_v[0] = mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);
        exp_v[1] = mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1, 1);
        exp_v[2] = 25'h0;
        for (int i = 0; i < 3; i++) begin
            bus.Run = (i == 0);
            bus.DIN = 16'hF000;
            #2;
            obs = observed();
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL illegal_step[%0d] got %h expected %h", i, obs, exp_v[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_abort();
        logic [24:0] obs;
        logic [24:0] exp_v [3];
        logic [24:0] exp_mv [3];
        exp_v[0] = mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);
        exp_v[1] = mk(0, 8'h02, 8'h00, 0, 1, 0, 0, 2'b00, 0, 1);
        exp_v[2] = mk(0, 8'h04, 8'h00, 0, 0, 1, 0, 2'b01, 0, 1);
        for (int i = 0; i < 3; i++) begin
            bus.Run = (i == 0);
            bus.DIN = 16'h3280;
            #2;
            obs = observed();
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL abort_pre[%0d] got %h expected %h", i, obs, exp_v[i]);
            end
            if (i < 2) next_cycle();
        end
        Resetn = 1'b0;
        #1;
        obs = observed();
        checks++;
        if (obs !== 25'h0) begin
            errors++;
            $display("FAIL abort_now got %h expected %h", obs, 25'h0);
        end
        checks++;
        if (dut.ir !== 16'h0000) begin
            errors++;
            $display("FAIL abort_ir got %h expected %h", dut.ir, 16'h0000);
        end
        next_cycle();
        #2;
        obs = observed();
        checks++;
        if (obs !== 25'h0) begin
            errors++;
            $display("FAIL abort_no_t3 got %h expected %h", obs, 25'h0);
        end
        next_cycle();
        Resetn = 1'b1;
        #2;
        obs = observed();
        checks++;
        if (obs !== 25'h0) begin
            errors++;
            $display("FAIL abort_release got %h expected %h", obs, 25'h0);
        end
        next_cycle();
        exp_mv[0] = mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);
        exp_mv[1] = mk(0, 8'h80, 8'h01, 0, 0, 0, 0, 2'b00, 1, 1);
        exp_mv[2] = 25'h0;
        for (int i = 0; i < 3; i++) begin
            bus.Run = (i == 0);
            bus.DIN = 16'h01C0;
            #2;
            obs = observed();
            checks++;
            if (obs !== exp_mv[i]) begin
                errors++;
                $display("FAIL mv_after_abort[%0d] got %h expected %h", i, obs, exp_mv[i]);
            end
            next_cycle();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mvi();
        test_add();
        test_back_to_back();
        test_illegal();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
